fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the PC value loaded on reset.
REQ-002 Parameter WIDTH, default 16, is the PC, address and instruction width; all buses below are WIDTH bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc  output  WIDTH  current PC; drives operand a of the downstream incrementer (operand b tied to 1 outside this block).
REQ-006 pc_inc  input  WIDTH  incrementer result (pc + 1), consumed as the sequential next PC.
REQ-007 branch_taken  input  1  redirect request, single-cycle pulse.
REQ-008 branch_target  input  WIDTH  redirect address, valid when branch_taken=1.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  WIDTH  request address, always equal to pc.
REQ-011 imem_gnt  input  1  memory accepts request this cycle.
REQ-012 imem_rvalid  input  1  read data valid; earliest one cycle after grant.
REQ-013 imem_rdata  input  WIDTH  read data.
REQ-014 instr  output  WIDTH  fetched instruction.
REQ-015 instr_pc  output  WIDTH  address instr was fetched from.
REQ-016 instr_valid  output  1  instr/instr_pc valid.
REQ-017 instr_ready  input  1  consumer accepts instr.

Function
REQ-018 Four states: REQ, WAIT, HOLD, DRAIN; one request outstanding at most.
REQ-019 imem_req = 1 only in REQ and only while reset is low; imem_addr = pc combinationally.
REQ-020 REQ, imem_gnt=1, branch_taken=0: req_pc <= pc, pc <= pc_inc, -> WAIT.
REQ-021 REQ, imem_gnt=1, branch_taken=1: pc <= branch_target, -> DRAIN (granted fetch is stale).
REQ-022 REQ, imem_gnt=0, branch_taken=1: pc <= branch_target, stay REQ.
REQ-023 WAIT, imem_rvalid=1, branch_taken=0: instr <= imem_rdata, instr_pc <= req_pc, instr_valid <= 1, -> HOLD.
REQ-024 WAIT, imem_rvalid=1, branch_taken=1: data discarded, pc <= branch_target, -> REQ.
REQ-025 WAIT, imem_rvalid=0, branch_taken=1: pc <= branch_target, -> DRAIN.
REQ-026 HOLD: instr, instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-027 HOLD, instr_ready=1, branch_taken=0: instr_valid <= 0, -> REQ.
REQ-028 HOLD, branch_taken=1 (any instr_ready): instr_valid <= 0, pc <= branch_target, -> REQ; held instr counts as delivered only if instr_ready=1 that cycle.
REQ-029 DRAIN: on imem_rvalid=1 discard data, -> REQ; branch_taken in DRAIN updates pc, stays DRAIN unless rvalid also 1 (then -> REQ with new pc).
REQ-030 branch_taken always has priority over sequential pc_inc update.
REQ-031 PC arithmetic is the incrementer's: pc 16'hFFFF followed by pc_inc 16'h0000 wraps with no flag.
REQ-032 imem_rvalid outside WAIT/DRAIN is ignored.
REQ-033 Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD with instr_ready=1).

Reset
REQ-034 reset asserted: immediately pc=RESET_PC, state=REQ, instr_valid=0, instr=0, instr_pc=0, req_pc=0, imem_req=0.
REQ-035 Reset mid-operation abandons any outstanding fetch; a response arriving after reset deassertion in REQ is ignored.
REQ-036 First imem_req=1 in the first cycle with reset low.

Verification
REQ-037 Reset release, gnt=1, rvalid one cycle later with 16'hA001, ready=1 -> instr=16'hA001, instr_pc=16'h0000, next imem_addr=16'h0001.
REQ-038 HOLD with instr_ready=0 for 5 cycles -> instr/instr_pc/instr_valid unchanged, imem_req=0 throughout.
REQ-039 branch_taken with target 16'h0040 in WAIT, rvalid next cycle with 16'hDEAD -> 16'hDEAD never presented, next imem_addr=16'h0040.
REQ-040 pc=16'hFFFF fetched -> instr_pc=16'hFFFF, next imem_addr=16'h0000.
REQ-041 branch_taken and imem_gnt same cycle in REQ, target 16'h0100 -> DRAIN, response dropped, next request address 16'h0100.
REQ-042 reset asserted in WAIT -> instr_valid=0 and pc=RESET_PC immediately; late rvalid produces no instr_valid.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM (REQ -> WAIT -> HOLD) with branch redirect and stale-response drain
// Ports: clk, reset (async, active-high); pc/pc_inc to and from the external incrementer;
// branch_taken/branch_target redirect; imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata memory side;
// instr/instr_pc/instr_valid/instr_ready consumer side.
module fetch_unit #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc_inc,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready
);
  localparam logic [1:0] REQ = 2'd0, WAIT = 2'd1, HOLD = 2'd2, DRAIN = 2'd3;
  logic [1:0] state;
  logic [WIDTH-1:0] req_pc;
  assign imem_req = (state == REQ) && !reset;
  assign imem_addr = pc;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= REQ;
      pc <= RESET_PC;
      req_pc <= '0;
      instr <= '0;
      instr_pc <= '0;
      instr_valid <= 1'b0;
    end else
      case (state)
        REQ:
          if (branch_taken) begin
            pc <= branch_target;
            // a fetch granted in the same cycle targets the old path and must be drained
            state <= imem_gnt ? DRAIN : REQ;
          end else if (imem_gnt) begin
            req_pc <= pc;
            pc <= pc_inc;
            state <= WAIT;
          end
        WAIT:
          if (branch_taken) begin
            pc <= branch_target;
            state <= imem_rvalid ? REQ : DRAIN;
          end else if (imem_rvalid) begin
            instr <= imem_rdata;
            instr_pc <= req_pc;
            instr_valid <= 1'b1;
            state <= HOLD;
          end
        HOLD:
          if (branch_taken || instr_ready) begin
            instr_valid <= 1'b0;
            state <= REQ;
            if (branch_taken) pc <= branch_target;
          end
        DRAIN: begin
          if (branch_taken) pc <= branch_target;
          if (imem_rvalid) state <= REQ;
        end
      endcase
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a program-order scoreboard
module tb_fetch_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] pc, pc_inc, branch_target, imem_addr, imem_rdata, instr, instr_pc;
  logic branch_taken, imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;
  assign pc_inc = pc + 16'd1;

  fetch_unit dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_inc(pc_inc),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a * 16'd7 + 16'h1234;
  endfunction

  task automatic idle();
    branch_taken = 0; branch_target = '0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; instr_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    repeat (2) @(negedge clk);
    vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL reset_pc got %h exp 0000", pc); end
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", imem_req); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    vectors++; if (instr !== 16'h0000) begin miscompares++; $display("FAIL reset_instr got %h exp 0000", instr); end
    vectors++; if (instr_pc !== 16'h0000) begin miscompares++; $display("FAIL reset_instr_pc got %h exp 0000", instr_pc); end
  endtask

  task automatic test_first_fetch();
    reset = 0; imem_gnt = 1; #1;
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req got %b exp 1", imem_req); end
    vectors++; if (imem_addr !== 16'h0000) begin miscompares++; $display("FAIL first_addr got %h exp 0000", imem_addr); end
    @(negedge clk);
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 16'hA001;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL wait_req got %b exp 0", imem_req); end
    @(negedge clk);
    imem_rvalid = 0;
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL first_valid got %b exp 1", instr_valid); end
    vectors++; if (instr !== 16'hA001) begin miscompares++; $display("FAIL first_instr got %h exp A001", instr); end
    vectors++; if (instr_pc !== 16'h0000) begin miscompares++; $display("FAIL first_instr_pc got %h exp 0000", instr_pc); end
  endtask

  task automatic test_hold();
    instr_ready = 0; imem_rvalid = 1; imem_rdata = 16'hFFFF;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (instr_valid !== 1'b1 || instr !== 16'hA001 || instr_pc !== 16'h0000 || imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL hold got valid=%b instr=%h pc=%h req=%b exp 1 A001 0000 0", instr_valid, instr, instr_pc, imem_req);
      end
    end
    imem_rvalid = 0; instr_ready = 1;
    @(negedge clk);
    instr_ready = 0;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release_valid got %b exp 0", instr_valid); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin miscompares++; $display("FAIL next_addr got req=%b addr=%h exp 1 0001", imem_req, imem_addr); end
  endtask

  task automatic test_branch_wait();
    imem_gnt = 1;
    @(negedge clk);
    imem_gnt = 0; branch_taken = 1; branch_target = 16'h0040;
    @(negedge clk);
    branch_taken = 0; imem_rvalid = 1; imem_rdata = 16'hDEAD;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL drain_req got %b exp 0", imem_req); end
    @(negedge clk);
    imem_rvalid = 0;
    vectors++; if (instr_valid !== 1'b0 || instr === 16'hDEAD) begin miscompares++; $display("FAIL stale_dead got valid=%b instr=%h exp 0 not DEAD", instr_valid, instr); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin miscompares++; $display("FAIL branch_addr got req=%b addr=%h exp 1 0040", imem_req, imem_addr); end
  endtask

  task automatic test_branch_gnt();
    imem_gnt = 1; branch_taken = 1; branch_target = 16'h0100;
    @(negedge clk);
    imem_gnt = 0; branch_taken = 0;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL gnt_branch_req got %b exp 0", imem_req); end
    imem_rvalid = 1; imem_rdata = 16'hBEEF;
    @(negedge clk);
    imem_rvalid = 0;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL gnt_branch_valid got %b exp 0", instr_valid); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin miscompares++; $display("FAIL gnt_branch_addr got req=%b addr=%h exp 1 0100", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    branch_taken = 1; branch_target = 16'hFFFF;
    @(negedge clk);
    branch_taken = 0;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_addr got req=%b addr=%h exp 1 FFFF", imem_req, imem_addr); end
    imem_gnt = 1;
    @(negedge clk);
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 16'h5678;
    @(negedge clk);
    imem_rvalid = 0;
    vectors++; if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFF || instr !== 16'h5678) begin miscompares++; $display("FAIL wrap_instr got valid=%b pc=%h instr=%h exp 1 FFFF 5678", instr_valid, instr_pc, instr); end
    instr_ready = 1;
    @(negedge clk);
    instr_ready = 0;
    vectors++; if (imem_addr !== 16'h0000) begin miscompares++; $display("FAIL wrap_next got %h exp 0000", imem_addr); end
  endtask

  task automatic test_reset_wait();
    imem_gnt = 1;
    @(negedge clk);
    imem_gnt = 0;
    vectors++; if (pc !== 16'h0001) begin miscompares++; $display("FAIL wait_pc got %h exp 0001", pc); end
    #2 reset = 1;
    #1;
    vectors++; if (pc !== 16'h0000 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin miscompares++; $display("FAIL async_reset got pc=%h valid=%b req=%b exp 0000 0 0", pc, instr_valid, imem_req); end
    vectors++; if (instr !== 16'h0000 || instr_pc !== 16'h0000) begin miscompares++; $display("FAIL async_reset_instr got %h %h exp 0000 0000", instr, instr_pc); end
    @(negedge clk);
    reset = 0; imem_rvalid = 1; imem_rdata = 16'hCAFE;
    @(negedge clk);
    imem_rvalid = 0;
    vectors++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin miscompares++; $display("FAIL late_rvalid got valid=%b req=%b addr=%h exp 0 1 0000", instr_valid, imem_req, imem_addr); end
    @(negedge clk);
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL late_rvalid2 got %b exp 0", instr_valid); end
  endtask

  task automatic test_throughput();
    logic pend = 0;
    logic [15:0] pa = '0;
    int got = 0;
    instr_ready = 1;
    repeat (30) begin
      @(negedge clk);
      if (instr_valid) got++;
      imem_rvalid = pend; imem_rdata = mem_word(pa); pend = 0;
      imem_gnt = imem_req;
      if (imem_req) begin pend = 1; pa = imem_addr; end
    end
    idle();
    vectors++; if (got != 10) begin miscompares++; $display("FAIL throughput got %0d exp 10", got); end
  endtask

  task automatic test_random();
    logic busy = 0, prev_hold = 0;
    logic [15:0] maddr = '0, exp_pc = 16'h0000, prev_instr = '0, prev_ipc = '0;
    int lat = 0, delivered = 0;
    reset = 1; idle();
    @(negedge clk);
    reset = 0;
    repeat (2000) begin
      @(negedge clk);
      vectors++; if (imem_addr !== pc) begin miscompares++; $display("FAIL rand_addr got %h exp %h", imem_addr, pc); end
      if (prev_hold) begin
        vectors++;
        if (instr_valid !== 1'b1 || instr !== prev_instr || instr_pc !== prev_ipc) begin
          miscompares++;
          $display("FAIL rand_stable got valid=%b instr=%h pc=%h exp 1 %h %h", instr_valid, instr, instr_pc, prev_instr, prev_ipc);
        end
      end
      imem_rvalid = 0; imem_rdata = 16'($urandom);
      if (busy) begin
        if (lat == 0) begin imem_rvalid = 1; imem_rdata = mem_word(maddr); busy = 0; end
        else lat--;
      end
      imem_gnt = imem_req && ($urandom_range(0, 9) < 7);
      if (imem_gnt) begin busy = 1; maddr = imem_addr; lat = int'($urandom_range(0, 2)); end
      branch_taken = ($urandom_range(0, 9) == 0);
      branch_target = 16'($urandom);
      instr_ready = ($urandom_range(0, 9) < 6);
      if (instr_valid && instr_ready) begin
        delivered++;
        vectors++;
        if (instr_pc !== exp_pc || instr !== mem_word(instr_pc)) begin
          miscompares++;
          $display("FAIL rand_deliver got pc=%h instr=%h exp %h %h", instr_pc, instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc = instr_pc + 16'd1;
      end
      if (branch_taken) exp_pc = branch_target;
      prev_hold = instr_valid && !instr_ready && !branch_taken;
      prev_instr = instr; prev_ipc = instr_pc;
    end
    idle();
    vectors++; if (delivered < 50) begin miscompares++; $display("FAIL rand_progress got %0d exp >=50", delivered); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold();
    test_branch_wait();
    test_branch_gnt();
    test_wrap();
    test_reset_wait();
    test_throughput();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
